// File: rtl/iommu_mon_pkg.sv
// Shared types and constants for the IOMMU AXI protocol monitor.
package iommu_mon_pkg;

  localparam int unsigned N_ERR = 8;
  localparam int unsigned N_CH  = 5;

  typedef enum logic [2:0] {
    ErrArStable      = 3'd0,
    ErrAwStable      = 3'd1,
    ErrRNoReq        = 3'd2,
    ErrBNoReq        = 3'd3,
    ErrWLastMismatch = 3'd4,
    ErrWNoAw         = 3'd5,
    ErrOutstOvf      = 3'd6,
    ErrTimeout       = 3'd7
  } err_idx_e;

  typedef enum logic [2:0] {
    ChAr = 3'd0,
    ChR  = 3'd1,
    ChAw = 3'd2,
    ChW  = 3'd3,
    ChB  = 3'd4
  } chan_e;

  function automatic logic [2:0] lowest_set(input logic [N_ERR-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = N_ERR - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/iommu_mon_len_fifo.sv
// Synchronous FIFO of AW burst lengths; head shows the incoming entry when empty.
module iommu_mon_len_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] data_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [7:0] head_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          wr_en, rd_en;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign head_o  = empty_o ? data_i : mem_q[rd_ptr_q];

  // A push consumed by a same-cycle pop on an empty FIFO never gets stored.
  assign wr_en = push_i && !full_o && !(empty_o && pop_i);
  assign rd_en = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wrap_inc(wr_ptr_q);
      if (rd_en) rd_ptr_q <= wrap_inc(rd_ptr_q);
      cnt_q <= cnt_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/iommu_axi_monitor.sv
// Passive AXI4 monitor: outstanding tracking, handshake stability, W burst length,
// response legality and stall watchdogs with sticky/pulsed error reporting.
module iommu_axi_monitor
  import iommu_mon_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned MAX_OUTST  = 8,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   clear_i,
  input  logic                                   ar_valid_i,
  input  logic                                   ar_ready_i,
  input  logic [ID_WIDTH-1:0]                    ar_id_i,
  input  logic [ADDR_WIDTH-1:0]                  ar_addr_i,
  input  logic [7:0]                             ar_len_i,
  input  logic                                   r_valid_i,
  input  logic                                   r_ready_i,
  input  logic                                   r_last_i,
  input  logic [ID_WIDTH-1:0]                    r_id_i,
  input  logic                                   aw_valid_i,
  input  logic                                   aw_ready_i,
  input  logic [ID_WIDTH-1:0]                    aw_id_i,
  input  logic [ADDR_WIDTH-1:0]                  aw_addr_i,
  input  logic [7:0]                             aw_len_i,
  input  logic                                   w_valid_i,
  input  logic                                   w_ready_i,
  input  logic                                   w_last_i,
  input  logic                                   b_valid_i,
  input  logic                                   b_ready_i,
  input  logic [ID_WIDTH-1:0]                    b_id_i,
  output logic [N_ERR-1:0]                       err_o,
  output logic [N_ERR-1:0]                       err_pulse_o,
  output logic                                   first_err_valid_o,
  output logic [2:0]                             first_err_o,
  output logic [ID_WIDTH+$clog2(MAX_OUTST+1)-1:0] rd_outst_o,
  output logic [ID_WIDTH+$clog2(MAX_OUTST+1)-1:0] wr_outst_o
);

  localparam int unsigned N_ID = 1 << ID_WIDTH;
  localparam int unsigned CW   = $clog2(MAX_OUTST + 1);
  localparam int unsigned TW   = ID_WIDTH + CW;
  localparam int unsigned WW   = $clog2(TIMEOUT + 1);

  logic ar_hs, r_done, aw_hs, w_hs, b_hs;
  assign ar_hs  = ar_valid_i && ar_ready_i;
  assign r_done = r_valid_i && r_ready_i && r_last_i;
  assign aw_hs  = aw_valid_i && aw_ready_i;
  assign w_hs   = w_valid_i && w_ready_i;
  assign b_hs   = b_valid_i && b_ready_i;

  logic                  ar_pend_q, aw_pend_q;
  logic [ID_WIDTH-1:0]   ar_id_q, aw_id_q;
  logic [ADDR_WIDTH-1:0] ar_addr_q, aw_addr_q;
  logic [7:0]            ar_len_q, aw_len_q;

  logic [N_ID-1:0][CW-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [TW-1:0]           rd_tot_q, rd_tot_d, wr_tot_q, wr_tot_d;
  logic rd_same, rd_full, rd_zero, rd_inc, rd_dec;
  logic wr_same, wr_full, wr_zero, wr_inc, wr_dec;

  logic [N_CH-1:0]         stall;
  logic [N_CH-1:0][WW-1:0] wd_q, wd_d;
  logic                    wd_hit;

  logic       fifo_full, fifo_empty, have_head, w_is_last, w_end;
  logic [7:0] fifo_head, w_beat_q, w_beat_d;

  logic [N_ERR-1:0] det, err_q, err_pulse_q;
  logic             first_valid_q;
  logic [2:0]       first_q;

  iommu_mon_len_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_len_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (aw_hs),
    .pop_i   (w_end),
    .data_i  (aw_len_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  // Outstanding counters: a same-ID inc+dec cancels; saturate at 0 and MAX_OUTST.
  always_comb begin
    rd_same  = ar_hs && r_done && (ar_id_i == r_id_i);
    rd_full  = (rd_cnt_q[ar_id_i] == CW'(MAX_OUTST));
    rd_zero  = (rd_cnt_q[r_id_i] == '0);
    rd_inc   = ar_hs && !rd_same && !rd_full;
    rd_dec   = r_done && !rd_same && !rd_zero;
    rd_cnt_d = rd_cnt_q;
    if (rd_inc) rd_cnt_d[ar_id_i] = rd_cnt_q[ar_id_i] + 1'b1;
    if (rd_dec) rd_cnt_d[r_id_i] = rd_cnt_q[r_id_i] - 1'b1;
    rd_tot_d = rd_tot_q + TW'(rd_inc) - TW'(rd_dec);

    wr_same  = aw_hs && b_hs && (aw_id_i == b_id_i);
    wr_full  = (wr_cnt_q[aw_id_i] == CW'(MAX_OUTST));
    wr_zero  = (wr_cnt_q[b_id_i] == '0);
    wr_inc   = aw_hs && !wr_same && !wr_full;
    wr_dec   = b_hs && !wr_same && !wr_zero;
    wr_cnt_d = wr_cnt_q;
    if (wr_inc) wr_cnt_d[aw_id_i] = wr_cnt_q[aw_id_i] + 1'b1;
    if (wr_dec) wr_cnt_d[b_id_i] = wr_cnt_q[b_id_i] - 1'b1;
    wr_tot_d = wr_tot_q + TW'(wr_inc) - TW'(wr_dec);
  end

  always_comb begin
    stall       = '0;
    stall[ChAr] = ar_valid_i && !ar_ready_i;
    stall[ChR]  = r_valid_i && !r_ready_i;
    stall[ChAw] = aw_valid_i && !aw_ready_i;
    stall[ChW]  = w_valid_i && !w_ready_i;
    stall[ChB]  = b_valid_i && !b_ready_i;
    wd_d   = wd_q;
    wd_hit = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (!stall[c]) begin
        wd_d[c] = '0;
      end else if (wd_q[c] != WW'(TIMEOUT)) begin
        wd_d[c] = wd_q[c] + 1'b1;
        if (wd_q[c] == WW'(TIMEOUT - 1)) wd_hit = 1'b1;
      end
    end
  end

  always_comb begin
    have_head = !fifo_empty || aw_hs;
    w_is_last = (w_beat_q == fifo_head);
    w_end     = w_hs && have_head && (w_is_last || w_last_i);
    w_beat_d  = w_beat_q;
    if (w_end) w_beat_d = '0;
    else if (w_hs && have_head) w_beat_d = w_beat_q + 1'b1;

    det                   = '0;
    det[ErrArStable]      = ar_pend_q && (!ar_valid_i || ar_id_i != ar_id_q ||
                                          ar_addr_i != ar_addr_q || ar_len_i != ar_len_q);
    det[ErrAwStable]      = aw_pend_q && (!aw_valid_i || aw_id_i != aw_id_q ||
                                          aw_addr_i != aw_addr_q || aw_len_i != aw_len_q);
    det[ErrRNoReq]        = r_done && rd_zero;
    det[ErrBNoReq]        = b_hs && wr_zero;
    det[ErrWLastMismatch] = w_hs && have_head && (w_last_i != w_is_last);
    det[ErrWNoAw]         = w_hs && !have_head;
    det[ErrOutstOvf]      = (ar_hs && rd_full && !rd_same) || (aw_hs && wr_full && !wr_same) ||
                            (aw_hs && fifo_full);
    det[ErrTimeout]       = wd_hit;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ar_pend_q     <= 1'b0;
      aw_pend_q     <= 1'b0;
      ar_id_q       <= '0;
      aw_id_q       <= '0;
      ar_addr_q     <= '0;
      aw_addr_q     <= '0;
      ar_len_q      <= '0;
      aw_len_q      <= '0;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
      rd_tot_q      <= '0;
      wr_tot_q      <= '0;
      wd_q          <= '0;
      w_beat_q      <= '0;
      err_q         <= '0;
      err_pulse_q   <= '0;
      first_valid_q <= 1'b0;
      first_q       <= '0;
    end else begin
      ar_pend_q   <= ar_valid_i && !ar_ready_i;
      aw_pend_q   <= aw_valid_i && !aw_ready_i;
      ar_id_q     <= ar_id_i;
      aw_id_q     <= aw_id_i;
      ar_addr_q   <= ar_addr_i;
      aw_addr_q   <= aw_addr_i;
      ar_len_q    <= ar_len_i;
      aw_len_q    <= aw_len_i;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_tot_q    <= rd_tot_d;
      wr_tot_q    <= wr_tot_d;
      wd_q        <= wd_d;
      w_beat_q    <= w_beat_d;
      err_pulse_q <= det;
      err_q       <= (clear_i ? '0 : err_q) | det;
      if (clear_i) begin
        first_valid_q <= 1'b0;
        first_q       <= '0;
      end
      // A detection in the clearing cycle re-arms the capture immediately.
      if ((clear_i || !first_valid_q) && |det) begin
        first_valid_q <= 1'b1;
        first_q       <= lowest_set(det);
      end
    end
  end

  assign err_o             = err_q;
  assign err_pulse_o       = err_pulse_q;
  assign first_err_valid_o = first_valid_q;
  assign first_err_o       = first_q;
  assign rd_outst_o        = rd_tot_q;
  assign wr_outst_o        = wr_tot_q;

endmodule

// File: tb/tb_iommu_axi_monitor.sv
// Directed bench with a queue/array reference model compared every cycle.
module tb_iommu_axi_monitor;

  localparam int MAXO = 8;
  localparam int TMO  = 16;

  logic        clk = 1'b0;
  logic        rst, clear;
  logic        ar_valid, ar_ready, r_valid, r_ready, r_last;
  logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic [3:0]  ar_id, r_id, aw_id, b_id;
  logic [63:0] ar_addr, aw_addr;
  logic [7:0]  ar_len, aw_len;
  logic [7:0]  err, err_pulse;
  logic        first_valid;
  logic [2:0]  first_err;
  logic [7:0]  rd_outst, wr_outst;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  iommu_axi_monitor #(
    .ID_WIDTH   (4),
    .ADDR_WIDTH (64),
    .MAX_OUTST  (MAXO),
    .TIMEOUT    (TMO)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .clear_i           (clear),
    .ar_valid_i        (ar_valid),
    .ar_ready_i        (ar_ready),
    .ar_id_i           (ar_id),
    .ar_addr_i         (ar_addr),
    .ar_len_i          (ar_len),
    .r_valid_i         (r_valid),
    .r_ready_i         (r_ready),
    .r_last_i          (r_last),
    .r_id_i            (r_id),
    .aw_valid_i        (aw_valid),
    .aw_ready_i        (aw_ready),
    .aw_id_i           (aw_id),
    .aw_addr_i         (aw_addr),
    .aw_len_i          (aw_len),
    .w_valid_i         (w_valid),
    .w_ready_i         (w_ready),
    .w_last_i          (w_last),
    .b_valid_i         (b_valid),
    .b_ready_i         (b_ready),
    .b_id_i            (b_id),
    .err_o             (err),
    .err_pulse_o       (err_pulse),
    .first_err_valid_o (first_valid),
    .first_err_o       (first_err),
    .rd_outst_o        (rd_outst),
    .wr_outst_o        (wr_outst)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model state
  int          rc[16], wc[16], wd[5], beat;
  int          lenq[$];
  bit          model_on = 0;
  bit          p_ar, p_aw;
  logic [3:0]  p_ar_id, p_aw_id;
  logic [63:0] p_ar_addr, p_aw_addr;
  logic [7:0]  p_ar_len, p_aw_len;
  logic [7:0]  m_err, m_pulse;
  bit          m_fv;
  logic [2:0]  m_fe;
  int          m_rd, m_wr;

  always @(posedge clk) begin
    logic [7:0] det;
    logic [4:0] vld, rdy;
    bit         ar_hs, r_done, aw_hs, w_hs, b_hs;
    int         pre_size, exp_beats;
    if (rst) begin
      model_on = 1;
      foreach (rc[i]) begin rc[i] = 0; wc[i] = 0; end
      foreach (wd[i]) wd[i] = 0;
      lenq.delete();
      beat = 0; p_ar = 0; p_aw = 0;
      m_err = 0; m_pulse = 0; m_fv = 0; m_fe = 0; m_rd = 0; m_wr = 0;
    end else begin
      det    = 0;
      ar_hs  = ar_valid && ar_ready;
      r_done = r_valid && r_ready && r_last;
      aw_hs  = aw_valid && aw_ready;
      w_hs   = w_valid && w_ready;
      b_hs   = b_valid && b_ready;
      if (p_ar && (!ar_valid || {ar_id, ar_addr, ar_len} != {p_ar_id, p_ar_addr, p_ar_len}))
        det[0] = 1;
      if (p_aw && (!aw_valid || {aw_id, aw_addr, aw_len} != {p_aw_id, p_aw_addr, p_aw_len}))
        det[1] = 1;
      p_ar = ar_valid && !ar_ready; p_ar_id = ar_id; p_ar_addr = ar_addr; p_ar_len = ar_len;
      p_aw = aw_valid && !aw_ready; p_aw_id = aw_id; p_aw_addr = aw_addr; p_aw_len = aw_len;
      if (r_done && rc[r_id] == 0) det[2] = 1;
      if (b_hs && wc[b_id] == 0) det[3] = 1;
      if (ar_hs && rc[ar_id] == MAXO && !(r_done && r_id == ar_id)) det[6] = 1;
      if (aw_hs && wc[aw_id] == MAXO && !(b_hs && b_id == aw_id)) det[6] = 1;
      // Apply both deltas, then clamp into the legal range.
      if (ar_hs) rc[ar_id]++;
      if (r_done) rc[r_id]--;
      if (aw_hs) wc[aw_id]++;
      if (b_hs) wc[b_id]--;
      m_rd = 0; m_wr = 0;
      for (int i = 0; i < 16; i++) begin
        if (rc[i] < 0) rc[i] = 0;
        if (rc[i] > MAXO) rc[i] = MAXO;
        if (wc[i] < 0) wc[i] = 0;
        if (wc[i] > MAXO) wc[i] = MAXO;
        m_rd += rc[i]; m_wr += wc[i];
      end
      pre_size = lenq.size();
      if (aw_hs) begin
        if (pre_size == MAXO) det[6] = 1;
        else lenq.push_back(int'(aw_len));
      end
      if (w_hs) begin
        if (lenq.size() == 0) det[5] = 1;
        else begin
          exp_beats = lenq[0] + 1;
          if (w_last != (beat + 1 == exp_beats)) det[4] = 1;
          if (w_last || beat + 1 == exp_beats) begin
            void'(lenq.pop_front());
            beat = 0;
          end else beat++;
        end
      end
      vld = {b_valid, w_valid, aw_valid, r_valid, ar_valid};
      rdy = {b_ready, w_ready, aw_ready, r_ready, ar_ready};
      for (int c = 0; c < 5; c++) begin
        if (vld[c] && !rdy[c]) begin
          if (wd[c] < TMO) begin
            wd[c]++;
            if (wd[c] == TMO) det[7] = 1;
          end
        end else wd[c] = 0;
      end
      m_pulse = det;
      if (clear) begin m_err = 0; m_fv = 0; m_fe = 0; end
      m_err |= det;
      if (!m_fv && det != 0) begin
        m_fv = 1;
        for (int i = 7; i >= 0; i--) if (det[i]) m_fe = 3'(i);
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("err_o", err, m_err);
      check("err_pulse_o", err_pulse, m_pulse);
      check("first_err_valid_o", first_valid, m_fv);
      check("first_err_o", first_err, m_fe);
      check("rd_outst_o", rd_outst, m_rd);
      check("wr_outst_o", wr_outst, m_wr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {ar_valid, ar_ready, r_valid, r_ready, r_last} = '0;
    {aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready} = '0;
    {ar_id, r_id, aw_id, b_id} = '0;
    ar_addr = '0; aw_addr = '0; ar_len = '0; aw_len = '0;
  endtask

  task automatic do_clear();
    clear = 1; step(); clear = 0;
  endtask

  initial begin
    idle();
    rst = 1; clear = 0;
    repeat (3) step();
    rst = 0;
    check("reset err", err, 8'h00);
    check("reset rd_outst", rd_outst, 8'd0);
    check("reset first_valid", first_valid, 1'b0);

    // Single read: ID 3 outstanding then retired.
    ar_valid = 1; ar_ready = 1; ar_id = 3; ar_addr = 64'h40; step(); idle();
    check("rd after AR", rd_outst, 8'd1);
    r_valid = 1; r_ready = 1; r_last = 1; r_id = 3; step(); idle();
    check("rd after R", rd_outst, 8'd0);
    check("err after read", err, 8'h00);

    // AR address changes while stalled.
    ar_valid = 1; ar_addr = 64'h1000; step();
    ar_addr = 64'h2000; step();
    check("ar stable pulse", err_pulse, 8'h01);
    check("ar first valid", first_valid, 1'b1);
    check("ar first idx", first_err, 3'd0);
    ar_ready = 1; step(); idle();
    check("ar accept no pulse", err_pulse, 8'h00);
    r_valid = 1; r_ready = 1; r_last = 1; r_id = 0; step(); idle();
    do_clear();
    check("clear err", err, 8'h00);

    // AW len=3 with early w_last, then a clean bypassed single-beat burst.
    aw_valid = 1; aw_ready = 1; aw_id = 1; aw_len = 3; step(); idle();
    w_valid = 1; w_ready = 1; step(); step();
    w_last = 1; step(); idle();
    check("w_last mismatch", err, 8'h10);
    check("w_last first idx", first_err, 3'd4);
    b_valid = 1; b_ready = 1; b_id = 1; step(); idle();
    aw_valid = 1; aw_ready = 1; aw_id = 1; aw_len = 0;
    w_valid = 1; w_ready = 1; w_last = 1; step(); idle();
    check("bypass clean", err_pulse, 8'h00);
    check("wr after bypass", wr_outst, 8'd1);
    b_valid = 1; b_ready = 1; b_id = 1; step(); idle();
    do_clear();

    // Read overflow on ID 5.
    ar_valid = 1; ar_ready = 1; ar_id = 5;
    repeat (8) step();
    check("rd at max", rd_outst, 8'd8);
    step(); idle();
    check("rd ovf pulse", err_pulse, 8'h40);
    check("rd saturates", rd_outst, 8'd8);
    r_valid = 1; r_ready = 1; r_last = 1; r_id = 5;
    repeat (8) step();
    idle();
    check("rd drained", rd_outst, 8'd0);
    do_clear();

    // B with no request, then clear.
    b_valid = 1; b_ready = 1; b_id = 2; step(); idle();
    check("b no req", err, 8'h08);
    check("b first idx", first_err, 3'd3);
    do_clear();
    check("clear err 2", err, 8'h00);
    check("clear first_valid", first_valid, 1'b0);

    // AW valid dropped while stalled; write overflow also overflows the length FIFO.
    aw_valid = 1; aw_id = 6; step(); aw_valid = 0; step();
    check("aw stable pulse", err_pulse, 8'h02);
    aw_valid = 1; aw_ready = 1; aw_id = 4; aw_len = 0;
    repeat (9) step();
    idle();
    check("wr ovf", err & 8'h40, 8'h40);
    w_valid = 1; w_ready = 1; w_last = 1;
    repeat (9) step();
    idle();
    check("w no aw", err & 8'h20, 8'h20);
    b_valid = 1; b_ready = 1; b_id = 4;
    repeat (8) step();
    idle();
    do_clear();

    // W stall watchdog, then reset mid-stall with a read outstanding.
    ar_valid = 1; ar_ready = 1; ar_id = 7; step(); idle();
    w_valid = 1;
    repeat (15) step();
    check("no timeout yet", err_pulse, 8'h00);
    step();
    check("timeout pulse", err_pulse, 8'h80);
    step();
    check("timeout once", err_pulse, 8'h00);
    repeat (3) step();
    rst = 1; step(); rst = 0; idle();
    check("rst err", err, 8'h00);
    check("rst first_valid", first_valid, 1'b0);
    check("rst rd_outst", rd_outst, 8'd0);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iommu_axi_monitor.md
Name: iommu_axi_monitor

Overview:
- Synthesisable, parametrised AXI4 protocol monitor for the IOMMU translation-request and data-structure ports.
- Tracks outstanding transactions per ID and checks handshake stability, write-burst length and response legality.
- Runs a stall watchdog and reports sticky and pulsed error flags, so the same checks run in simulation, formal and silicon debug.
- Attached in parallel to an AXI port; it never drives the bus.

Parameters:
ID_WIDTH, 4, AXI ID width; one outstanding counter per ID (2**ID_WIDTH counters)
ADDR_WIDTH, 64, AXI address width (stability check only)
MAX_OUTST, 8, max outstanding reads (resp. writes) per ID; also AW-length FIFO depth
TIMEOUT, 1024, consecutive valid-without-ready cycles before TIMEOUT error
N_ERR, 8, number of error classes (fixed by package)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
clear_i  in  1  clears sticky errors and first-error capture
ar_valid_i, ar_ready_i  in  1 each  AR handshake
ar_id_i  in  ID_WIDTH  AR ID
ar_addr_i  in  ADDR_WIDTH  AR address
ar_len_i  in  8  AR burst length
r_valid_i, r_ready_i, r_last_i  in  1 each  R handshake, last beat
r_id_i  in  ID_WIDTH  R ID
aw_valid_i, aw_ready_i  in  1 each  AW handshake
aw_id_i  in  ID_WIDTH  AW ID
aw_addr_i  in  ADDR_WIDTH  AW address
aw_len_i  in  8  AW burst length
w_valid_i, w_ready_i, w_last_i  in  1 each  W handshake, last beat
b_valid_i, b_ready_i  in  1 each  B handshake
b_id_i  in  ID_WIDTH  B ID
err_o  out  N_ERR  sticky error flags
err_pulse_o  out  N_ERR  one-cycle flag per detection
first_err_valid_o  out  1  first error captured
first_err_o  out  3  index of first error since reset/clear
rd_outst_o  out  ID_WIDTH+$clog2(MAX_OUTST+1)  total outstanding reads
wr_outst_o  out  same  total outstanding writes

Behaviour:
- Reset state: all outputs and counters 0, FIFO empty, watchdogs 0. Reset mid-burst discards all tracking; no errors raised.
- Error indices: 0 AR_STABLE, 1 AW_STABLE, 2 R_NO_REQ, 3 B_NO_REQ, 4 W_LAST_MISMATCH, 5 W_NO_AW, 6 OUTST_OVF, 7 TIMEOUT.
- Detection is registered: condition in cycle N gives err_pulse_o in N+1 and err_o bit set from N+1.
- Stability (AR/AW): the previous cycle has valid=1 and ready=0. In the current cycle, valid=0 or any of id/addr/len changed -> flag.
- Read counter per ID:
  - +1 on AR handshake; -1 on R handshake with r_last_i.
  - R_NO_REQ when r_last handshake hits an ID whose pre-cycle count is 0. Same-cycle AR on that ID does not excuse it; count stays 0.
  - OUTST_OVF when an AR handshake occurs with pre-cycle count == MAX_OUTST and no same-cycle decrement on that ID. Count saturates.
- Write counter per ID: same rules using AW / B, with B_NO_REQ in place of R_NO_REQ.
- AW-length FIFO (depth MAX_OUTST) and W beat tracking:
  - Every AW handshake pushes aw_len_i.
  - A W beat counter compares against the FIFO head.
  - W_LAST_MISMATCH when w_last_i differs from (beat == head len) on a W handshake.
  - Pop on the last beat (head len reached or w_last_i); counter resets to 0.
  - W_NO_AW on a W handshake with the FIFO empty and no same-cycle AW handshake. A same-cycle AW is bypassed as head.
  - FIFO push when full: also flags OUTST_OVF; the push is dropped.
- Watchdog: one counter per channel (AR, R, AW, W, B).
  - Increments while valid & !ready; clears on ready or !valid.
  - Reaching TIMEOUT flags TIMEOUT once, then holds until cleared by a handshake.
- First error: first_err_o latches the lowest set index among pulses in the first cycle any pulse fires; first_err_valid_o goes 1.
- clear_i: zeroes err_o and the first-error capture. Detection in the same cycle wins (the flag stays set). Counters are not cleared.
- Totals: rd_outst_o / wr_outst_o are registered sums, updated by ±1 each cycle alongside the per-ID counters.

Decomposition:
- Package iommu_mon_pkg holds:
  - err_idx_e enum (the 8 indices above)
  - N_ERR constant
  - channel enum for the watchdogs
- Sub-module iommu_mon_len_fifo:
  - 8-bit wide, MAX_OUTST deep, synchronous FIFO.
  - Ports: push, pop, full, empty, head, plus a bypass head for same-cycle push on empty.

Test Plan:
- AR id=3 len=0, then R id=3 last -> rd counter[3] 0→1→0; rd_outst_o 1 then 0; err_o=0.
- ar_valid high with ready=0, ar_addr changes 0x1000→0x2000 next cycle -> err_pulse_o[0] one cycle later; first_err_o=0, first_err_valid_o=1.
- AW len=3, W beats with w_last on beat 2 -> err_o[4]=1; the following AW len=0 / W last beat is accepted cleanly.
- 9 ARs on id=5 with MAX_OUTST=8 and no R -> err_o[6] on the 9th; counter stays 8.
- B id=2 with no prior AW -> err_o[3]; clear_i pulse -> err_o=0, first_err_valid_o=0.
- w_valid held with w_ready=0 for TIMEOUT=16 cycles -> single err_pulse_o[7] at cycle 17; a reset mid-stall returns all outputs to 0.
